seg_disp_sched: RTL and testbench

Round-robin scheduler that shares the board's 2-digit hex 7-segment display between several byte sources, such as UART RX data, UART TX data and a status byte. Each granted byte is held on the display for a fixed dwell time before the next pending source is served. Its outputs drive the 8-bit number input of the display multiplexer. Sources use a valid/ready handshake so that each byte is consumed exactly once.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/rr_pick.sv | 47 ++++
 rtl/seg_disp_sched.sv | 106 ++++++++++
 tb/tb_seg_disp_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared types and defaults for the 7-segment display scheduler.
//             Holds the scheduler state encoding, default source count and
//             data width, and a short dwell value suitable for simulation.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam int NREQ_DEF        = 3;
  localparam int DW_DEF          = 8;
  localparam int HOLD_CYCLES_SIM = 4;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin priority encoder. Finds the first
//             asserted request starting at position ptr and wrapping modulo
//             NREQ. Reusable by any shared-resource arbiter.
//  Ports    : req    in  NREQ  request vector
//             ptr    in  PW    search start position (must be < NREQ)
//             any    out 1     at least one request asserted
//             idx    out PW    index of the winning request (0 if none)
//             onehot out NREQ  one-hot winner (all 0 if none)
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx,
  output logic [NREQ-1:0] onehot
);

  int cand;

  // Scan from the farthest candidate back to ptr itself so that the last
  // hit written is the nearest one in round-robin order.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) begin
        any          = 1'b1;
        idx          = PW'(cand);
        onehot       = '0;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/seg_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : seg_disp_sched
//  Purpose  : Round-robin scheduler sharing a hex 7-segment display between
//             NREQ byte sources. A granted byte is shown for HOLD_CYCLES
//             clocks (or until skip), then the next pending source is served.
//  Ports    : clk        in  1       system clock
//             rst_n      in  1       asynchronous active-low reset
//             req_valid  in  NREQ    per-source byte pending
//             req_data   in  NREQ*DW packed data, source i at [i*DW +: DW]
//             req_ready  out NREQ    one-hot grant (Mealy, only in IDLE)
//             skip       in  1       end the current dwell early
//             disp_num   out DW      value to display
//             disp_src   out 3       index of the source shown
//             disp_valid out 1       set by the first grant after reset
//             busy       out 1       high while a byte is being shown
//  Revision : 1.0  initial release
// ============================================================================
module seg_disp_sched
  import seg_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int DW          = DW_DEF,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               skip,
  output logic [DW-1:0]      disp_num,
  output logic [2:0]         disp_src,
  output logic               disp_valid,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NREQ - 1);

  state_t          state;
  logic [CW-1:0]   hold_cnt;
  logic [PW-1:0]   rr_ptr;

  logic            pick_any;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Grant is offered only while idle; gating with rst_n keeps ready low for
  // the whole time reset is held, not just after the first clock.
  assign req_ready = (state == IDLE && rst_n) ? pick_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      disp_num   <= '0;
      disp_src   <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      hold_cnt   <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            disp_num   <= req_data[int'(pick_idx)*DW +: DW];
            disp_src   <= 3'(pick_idx);
            disp_valid <= 1'b1;
            rr_ptr     <= (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
            hold_cnt   <= '0;
            busy       <= 1'b1;
            state      <= SHOW;
          end
        end
        SHOW: begin
          if (hold_cnt == HOLD_LAST || skip) begin
            hold_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : seg_disp_sched
`default_nettype wire

// File: tb/tb_seg_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_disp_sched
//  Purpose  : Self-checking bench for seg_disp_sched (NREQ=3, DW=8, short
//             dwell). Stimulus pushes the expected display sequence into a
//             queue; a monitor pops an entry at each new dwell and checks
//             value, source and dwell length.
//  Ports    : (none)
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_disp_sched;
  import seg_pkg::*;

  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int HOLD = HOLD_CYCLES_SIM;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            skip;
  logic [DW-1:0]   disp_num;
  logic [2:0]      disp_src;
  logic            disp_valid;
  logic            busy;

  seg_disp_sched #(
    .NREQ        (NREQ),
    .DW          (DW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .skip       (skip),
    .disp_num   (disp_num),
    .disp_src   (disp_src),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] num;
    logic [2:0] src;
    int         dwell;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] num, input logic [2:0] src,
                      input int dwell);
    exp_t e;
    e.num = num; e.src = src; e.dwell = dwell;
    q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a rising busy marks a new displayed byte; the number of
  // negedge samples with busy high is the dwell length.
  exp_t cur;
  logic prev_busy = 1'b0;
  int   cnt = 0;
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      cnt = 1;
      if (q.size() == 0) begin
        check("unexpected_grant", {24'h0, disp_num}, 32'hFFFF_FFFF);
        cur.num = disp_num; cur.src = disp_src; cur.dwell = -1;
      end else begin
        cur = q.pop_front();
        check("grant_num", {24'h0, disp_num}, {24'h0, cur.num});
        check("grant_src", {29'h0, disp_src}, {29'h0, cur.src});
        check("grant_valid", {31'h0, disp_valid}, 32'h1);
      end
    end else if (busy && prev_busy) begin
      cnt = cnt + 1;
    end else if (!busy && prev_busy) begin
      if (cur.dwell >= 0) check("dwell_len", cnt, cur.dwell);
    end
    prev_busy = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b001;
    req_data  = '0;
    skip      = 1'b0;
    #1;
    // Ready must stay low while reset is held even with a request pending.
    check("rst_ready", {29'h0, req_ready}, 32'h0);
    check("rst_outputs", {21'h0, disp_valid, busy, disp_src, disp_num}, 32'h0);
    req_valid = 3'b000;
    tick(2);
    rst_n = 1'b1;

    // Idle with no requests: nothing moves.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_quiet", {18'h0, disp_valid, busy, req_ready, disp_num}, 32'h0);
    end

    // Single source held valid: re-granted every HOLD+1 cycles.
    req_data[7:0] = 8'h5A;
    req_valid     = 3'b001;
    #1;
    check("single_ready", {29'h0, req_ready}, 32'h1);
    push(8'h5A, 3'd0, HOLD);
    push(8'h5A, 3'd0, HOLD);
    push(8'h5A, 3'd0, HOLD);
    tick(11);
    req_valid = 3'b000;
    tick(6);

    // Reset pulse while idle returns rr_ptr to 0 before the rotation test.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_idle_dv", {31'h0, disp_valid}, 32'h0);

    // All three sources continuous, then src2 drops after src1 is served.
    req_data  = {8'h33, 8'h22, 8'h11};
    req_valid = 3'b111;
    #1;
    check("rot_ready", {29'h0, req_ready}, 32'h1);
    push(8'h11, 3'd0, HOLD);
    push(8'h22, 3'd1, HOLD);
    push(8'h33, 3'd2, HOLD);
    push(8'h11, 3'd0, HOLD);
    push(8'h22, 3'd1, HOLD);
    push(8'h11, 3'd0, HOLD);
    push(8'h22, 3'd1, HOLD);
    tick(2);
    req_data[7:0] = 8'hEE;          // change after grant: must not show
    tick();
    check("data_sampled_once", {24'h0, disp_num}, 32'h11);
    tick();
    req_data[7:0] = 8'h11;
    tick(17);
    req_valid = 3'b011;
    tick(10);
    req_valid = 3'b000;
    tick(6);

    // Skip at hold_cnt=1 gives a 2-cycle dwell; skip in IDLE is ignored.
    req_data[23:16] = 8'h7C;
    req_valid       = 3'b100;
    push(8'h7C, 3'd2, 2);
    push(8'h7C, 3'd2, HOLD);
    tick(2);
    skip = 1'b1;
    tick();
    check("skip_regrant_ready", {29'h0, req_ready}, 32'h4);
    tick();
    skip      = 1'b0;
    req_valid = 3'b000;
    tick(6);

    // Reset mid-dwell while 0x33 is shown, with rr_ptr left at 2.
    req_data[15:8] = 8'h33;
    req_valid      = 3'b010;
    push(8'h33, 3'd1, 1);
    tick();
    req_valid = 3'b000;
    check("pre_rst_num", {24'h0, disp_num}, 32'h33);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {22'h0, disp_valid, busy, disp_num}, 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_data  = {8'hC3, 8'hB2, 8'hA1};
    req_valid = 3'b111;
    #1;
    check("post_rst_ready", {29'h0, req_ready}, 32'h1);
    push(8'hA1, 3'd0, HOLD);
    tick();
    req_valid = 3'b000;
    tick(7);

    check("queue_drained", q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_seg_disp_sched
`default_nettype wire
